// File: rtl/dcache_l2_bridge.sv
// Cache-line bridge: one buffered refill and one buffered writeback, each moved as block_size word beats.
// Optional build macro DCACHE_BRIDGE_WB_FWD_EN serves a refill from the last completed writeback line.
module dcache_l2_bridge #(
  parameter int data_width    = 32,
  parameter int address_width = 32,
  parameter int block_size    = 32,
  localparam int offset_width    = $clog2(data_width*block_size/8),
  localparam int line_addr_width = address_width - offset_width,
  localparam int cache_width     = block_size*data_width,
  localparam int beat_width      = $clog2(block_size)
) (
  input  logic                       CLK,
  input  logic                       RST_N,
  input  logic                       ADDR_TO_L2_VALID,
  input  logic [line_addr_width-1:0] ADDR_TO_L2,
  output logic [cache_width-1:0]     DATA_FROM_L2,
  output logic                       DATA_FROM_L2_VALID,
  input  logic                       DATA_TO_L2_VALID,
  input  logic [cache_width-1:0]     DATA_TO_L2,
  input  logic [line_addr_width-1:0] WADDR_TO_L2,
  output logic                       WRITE_DONE,
  output logic                       MEM_REQ,
  output logic                       MEM_WE,
  output logic [address_width-1:0]  MEM_ADDR,
  output logic [data_width-1:0]      MEM_WDATA,
  input  logic                       MEM_GNT,
  input  logic [data_width-1:0]      MEM_RDATA,
  input  logic                       MEM_RVALID,
  output logic                       OVERRUN
);

  localparam int byte_width = offset_width - beat_width;
  localparam logic [beat_width-1:0] last_beat = beat_width'(block_size - 1);
  localparam logic [byte_width-1:0] byte_zero = '0;

  typedef enum logic [2:0] {IDLE, WB_BURST, RD_ISSUE, RD_DRAIN, RD_RET} state_e;

  state_e                     state_q, state_d;
  logic [beat_width-1:0]      beat_q, beat_d, ret_q, ret_d;
  logic                       rd_pend_q, rd_pend_d, wb_pend_q, wb_pend_d;
  logic [line_addr_width-1:0] rd_addr_q, rd_addr_d, wb_addr_q, wb_addr_d;
  logic [cache_width-1:0]     wb_line_q, wb_line_d, asm_q, asm_d, line_q, line_d;
  logic                       rd_prev_q, wb_prev_q, overrun_q, overrun_d, done_q, done_d;
  logic                       mem_req_q, mem_req_d, mem_we_q, mem_we_d;
  logic [address_width-1:0]   mem_addr_q, mem_addr_d;
  logic [data_width-1:0]      mem_wdata_q, mem_wdata_d;
  logic                       rd_rise, wb_rise, hs, rd_clr, wb_clr, fwd_hit;
  logic [cache_width-1:0]     fwd_line;

  assign rd_rise = ADDR_TO_L2_VALID & ~rd_prev_q;
  assign wb_rise = DATA_TO_L2_VALID & ~wb_prev_q;
  assign hs      = mem_req_q & MEM_GNT;

  // Writeback wins in IDLE so a refill never overtakes an older eviction of the same line.
  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    ret_d   = ret_q;
    asm_d   = asm_q;
    line_d  = line_q;
    done_d  = 1'b0;
    rd_clr  = 1'b0;
    wb_clr  = 1'b0;
    case (state_q)
      IDLE: begin
        beat_d = '0;
        ret_d  = '0;
        if (wb_pend_q) begin
          state_d = WB_BURST;
        end else if (rd_pend_q) begin
          if (fwd_hit) begin
            state_d = RD_RET;
            line_d  = fwd_line;
            rd_clr  = 1'b1;
          end else begin
            state_d = RD_ISSUE;
          end
        end
      end
      WB_BURST: begin
        if (hs) begin
          beat_d = beat_q + 1'b1;
          if (beat_q == last_beat) begin
            wb_clr  = 1'b1;
            done_d  = 1'b1;
            state_d = IDLE;
          end
        end
      end
      RD_ISSUE, RD_DRAIN: begin
        if (state_q == RD_ISSUE && hs) begin
          beat_d = beat_q + 1'b1;
          if (beat_q == last_beat) state_d = RD_DRAIN;
        end
        if (MEM_RVALID) begin
          asm_d[int'(ret_q)*data_width +: data_width] = MEM_RDATA;
          ret_d = ret_q + 1'b1;
          if (ret_q == last_beat) begin
            state_d = RD_RET;
            line_d  = asm_d;
            rd_clr  = 1'b1;
          end
        end
      end
      RD_RET:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Bus outputs are precomputed from the next state so they are registered and stay put until granted.
  always_comb begin
    mem_req_d   = (state_d == WB_BURST) || (state_d == RD_ISSUE);
    mem_we_d    = (state_d == WB_BURST);
    mem_addr_d  = '0;
    mem_wdata_d = '0;
    if (state_d == WB_BURST) begin
      mem_addr_d  = {wb_addr_q, beat_d, byte_zero};
      mem_wdata_d = wb_line_q[int'(beat_d)*data_width +: data_width];
    end else if (state_d == RD_ISSUE) begin
      mem_addr_d = {rd_addr_q, beat_d, byte_zero};
    end
  end

  // A request edge is only accepted while its buffer is empty; otherwise it is dropped and flagged.
  always_comb begin
    rd_pend_d = rd_pend_q & ~rd_clr;
    rd_addr_d = rd_addr_q;
    wb_pend_d = wb_pend_q & ~wb_clr;
    wb_addr_d = wb_addr_q;
    wb_line_d = wb_line_q;
    if (rd_rise && !rd_pend_q) begin
      rd_pend_d = 1'b1;
      rd_addr_d = ADDR_TO_L2;
    end
    if (wb_rise && !wb_pend_q) begin
      wb_pend_d = 1'b1;
      wb_addr_d = WADDR_TO_L2;
      wb_line_d = DATA_TO_L2;
    end
    overrun_d = overrun_q | (rd_rise & rd_pend_q) | (wb_rise & wb_pend_q);
  end

`ifdef DCACHE_BRIDGE_WB_FWD_EN
  logic                       fwd_vld_q;
  logic [line_addr_width-1:0] fwd_addr_q;
  logic [cache_width-1:0]     fwd_line_q;

  // Retained copy is invalid while a newer writeback is in flight.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      fwd_vld_q  <= 1'b0;
      fwd_addr_q <= '0;
      fwd_line_q <= '0;
    end else if (wb_clr) begin
      fwd_vld_q  <= 1'b1;
      fwd_addr_q <= wb_addr_q;
      fwd_line_q <= wb_line_q;
    end else if (state_q == IDLE && state_d == WB_BURST) begin
      fwd_vld_q  <= 1'b0;
    end
  end

  assign fwd_hit  = fwd_vld_q && (fwd_addr_q == rd_addr_q);
  assign fwd_line = fwd_line_q;
`else
  assign fwd_hit  = 1'b0;
  assign fwd_line = '0;
`endif

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= IDLE;
      beat_q      <= '0;
      ret_q       <= '0;
      rd_pend_q   <= 1'b0;
      wb_pend_q   <= 1'b0;
      rd_addr_q   <= '0;
      wb_addr_q   <= '0;
      wb_line_q   <= '0;
      asm_q       <= '0;
      line_q      <= '0;
      rd_prev_q   <= 1'b0;
      wb_prev_q   <= 1'b0;
      overrun_q   <= 1'b0;
      done_q      <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      beat_q      <= beat_d;
      ret_q       <= ret_d;
      rd_pend_q   <= rd_pend_d;
      wb_pend_q   <= wb_pend_d;
      rd_addr_q   <= rd_addr_d;
      wb_addr_q   <= wb_addr_d;
      wb_line_q   <= wb_line_d;
      asm_q       <= asm_d;
      line_q      <= line_d;
      rd_prev_q   <= ADDR_TO_L2_VALID;
      wb_prev_q   <= DATA_TO_L2_VALID;
      overrun_q   <= overrun_d;
      done_q      <= done_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign DATA_FROM_L2       = line_q;
  assign DATA_FROM_L2_VALID = (state_q == RD_RET);
  assign WRITE_DONE         = done_q;
  assign MEM_REQ            = mem_req_q;
  assign MEM_WE             = mem_we_q;
  assign MEM_ADDR           = mem_addr_q;
  assign MEM_WDATA          = mem_wdata_q;
  assign OVERRUN            = overrun_q;

endmodule

// File: tb/tb_dcache_l2_bridge.sv
// Directed bench for dcache_l2_bridge with a 3-cycle-latency memory responder and bus monitor.
module tb_dcache_l2_bridge;

  localparam int CW = 1024;

  logic          CLK = 1'b0;
  logic          RST_N = 1'b1;
  logic          ADDR_TO_L2_VALID = 1'b0;
  logic [24:0]   ADDR_TO_L2 = '0;
  logic [CW-1:0] DATA_FROM_L2;
  logic          DATA_FROM_L2_VALID;
  logic          DATA_TO_L2_VALID = 1'b0;
  logic [CW-1:0] DATA_TO_L2 = '0;
  logic [24:0]   WADDR_TO_L2 = '0;
  logic          WRITE_DONE;
  logic          MEM_REQ;
  logic          MEM_WE;
  logic [31:0]   MEM_ADDR;
  logic [31:0]   MEM_WDATA;
  logic          MEM_GNT = 1'b1;
  logic [31:0]   MEM_RDATA = '0;
  logic          MEM_RVALID = 1'b0;
  logic          OVERRUN;

  dcache_l2_bridge dut (
    .CLK(CLK), .RST_N(RST_N),
    .ADDR_TO_L2_VALID(ADDR_TO_L2_VALID), .ADDR_TO_L2(ADDR_TO_L2),
    .DATA_FROM_L2(DATA_FROM_L2), .DATA_FROM_L2_VALID(DATA_FROM_L2_VALID),
    .DATA_TO_L2_VALID(DATA_TO_L2_VALID), .DATA_TO_L2(DATA_TO_L2), .WADDR_TO_L2(WADDR_TO_L2),
    .WRITE_DONE(WRITE_DONE),
    .MEM_REQ(MEM_REQ), .MEM_WE(MEM_WE), .MEM_ADDR(MEM_ADDR), .MEM_WDATA(MEM_WDATA),
    .MEM_GNT(MEM_GNT), .MEM_RDATA(MEM_RDATA), .MEM_RVALID(MEM_RVALID),
    .OVERRUN(OVERRUN)
  );

  always #5 CLK = ~CLK;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int gnt_toggle = 0;
  int wr_cnt, rd_cnt, vld_cnt, done_cnt;
  int vld_cyc, done_cyc, last_wr_cyc, first_rd_cyc, last_rv_cyc;
  logic [31:0] wr_addr [64];
  logic [31:0] wr_data [64];
  logic [31:0] rd_addr [64];
  logic [CW-1:0] line_snap;
  int          q_due [$];
  logic [31:0] q_data [$];

  // Memory model and monitor: drive at the falling edge, sample 2ns later, well before the rising edge.
  always @(negedge CLK) begin
    cyc = cyc + 1;
    MEM_GNT = (gnt_toggle != 0) ? cyc[0] : 1'b1;
    if (q_due.size() > 0 && q_due[0] <= cyc) begin
      MEM_RVALID = 1'b1;
      MEM_RDATA  = q_data[0];
      void'(q_due.pop_front());
      void'(q_data.pop_front());
    end else begin
      MEM_RVALID = 1'b0;
      MEM_RDATA  = '0;
    end
    #2;
    if (MEM_RVALID) last_rv_cyc = cyc;
    if (MEM_REQ && MEM_GNT) begin
      if (MEM_WE) begin
        if (wr_cnt < 64) begin
          wr_addr[wr_cnt] = MEM_ADDR;
          wr_data[wr_cnt] = MEM_WDATA;
        end
        wr_cnt = wr_cnt + 1;
        last_wr_cyc = cyc;
      end else begin
        if (rd_cnt < 64) rd_addr[rd_cnt] = MEM_ADDR;
        if (rd_cnt == 0) first_rd_cyc = cyc;
        rd_cnt = rd_cnt + 1;
        q_due.push_back(cyc + 3);
        q_data.push_back(32'h100 + {27'b0, MEM_ADDR[6:2]});
      end
    end
    if (DATA_FROM_L2_VALID) begin
      vld_cnt   = vld_cnt + 1;
      vld_cyc   = cyc;
      line_snap = DATA_FROM_L2;
    end
    if (WRITE_DONE) begin
      done_cnt = done_cnt + 1;
      done_cyc = cyc;
    end
  end

  task automatic clear_stats();
    wr_cnt = 0; rd_cnt = 0; vld_cnt = 0; done_cnt = 0;
    vld_cyc = -1; done_cyc = -1; last_wr_cyc = -1; first_rd_cyc = -1; last_rv_cyc = -1;
    line_snap = '0;
  endtask

  task automatic set_line(input logic [31:0] base);
    for (int k = 0; k < 32; k++) DATA_TO_L2[k*32 +: 32] = base + 32'(k);
  endtask

  task automatic applyStimulus(input logic do_rd, input logic [24:0] raddr,
                               input logic do_wb, input logic [24:0] waddr, output int e);
    @(negedge CLK);
    #1;
    if (do_rd) begin ADDR_TO_L2 = raddr; ADDR_TO_L2_VALID = 1'b1; end
    if (do_wb) begin WADDR_TO_L2 = waddr; DATA_TO_L2_VALID = 1'b1; end
    e = cyc;
    @(negedge CLK);
    #1;
    ADDR_TO_L2_VALID = 1'b0;
    DATA_TO_L2_VALID = 1'b0;
  endtask

  task automatic wait_vld(input int limit);
    for (int i = 0; i < limit && vld_cnt == 0; i++) @(negedge CLK);
  endtask

  task automatic wait_done(input int limit);
    for (int i = 0; i < limit && done_cnt == 0; i++) @(negedge CLK);
  endtask

  task automatic test_reset();
    #1 RST_N = 1'b0;
    #1;
    total++; if (MEM_REQ !== 1'b0) begin bad++; $display("FAIL reset_req: got %b want 0", MEM_REQ); end
    total++; if (MEM_WE !== 1'b0) begin bad++; $display("FAIL reset_we: got %b want 0", MEM_WE); end
    total++; if (MEM_ADDR !== 32'h0) begin bad++; $display("FAIL reset_addr: got %h want 0", MEM_ADDR); end
    total++; if (MEM_WDATA !== 32'h0) begin bad++; $display("FAIL reset_wdata: got %h want 0", MEM_WDATA); end
    total++; if (DATA_FROM_L2 !== '0) begin bad++; $display("FAIL reset_line: low word %h want 0", DATA_FROM_L2[31:0]); end
    total++; if (DATA_FROM_L2_VALID !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", DATA_FROM_L2_VALID); end
    total++; if (WRITE_DONE !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", WRITE_DONE); end
    total++; if (OVERRUN !== 1'b0) begin bad++; $display("FAIL reset_overrun: got %b want 0", OVERRUN); end
    repeat (3) @(negedge CLK);
    #1 RST_N = 1'b1;
    repeat (2) @(negedge CLK);
    clear_stats();
  endtask

  task automatic test_refill();
    int e;
    gnt_toggle = 0;
    clear_stats();
    applyStimulus(1'b1, 25'h123, 1'b0, 25'h0, e);
    wait_vld(400);
    repeat (10) @(negedge CLK);
    total++; if (vld_cnt != 1) begin bad++; $display("FAIL refill_valid_count: got %0d want 1", vld_cnt); end
    total++; if (rd_cnt != 32) begin bad++; $display("FAIL refill_beats: got %0d want 32", rd_cnt); end
    total++; if (wr_cnt != 0) begin bad++; $display("FAIL refill_no_writes: got %0d want 0", wr_cnt); end
    for (int k = 0; k < 32; k++) begin
      total++;
      if (rd_addr[k] !== 32'h9180 + 32'(4*k)) begin
        bad++; $display("FAIL refill_addr[%0d]: got %h want %h", k, rd_addr[k], 32'h9180 + 32'(4*k));
      end
      total++;
      if (line_snap[k*32 +: 32] !== 32'h100 + 32'(k)) begin
        bad++; $display("FAIL refill_slot[%0d]: got %h want %h", k, line_snap[k*32 +: 32], 32'h100 + 32'(k));
      end
    end
    total++; if (vld_cyc != last_rv_cyc + 1) begin bad++; $display("FAIL refill_latency: valid cycle %0d want %0d", vld_cyc, last_rv_cyc + 1); end
    total++; if (DATA_FROM_L2[5*32 +: 32] !== 32'h105) begin bad++; $display("FAIL refill_hold_slot5: got %h want 00000105", DATA_FROM_L2[5*32 +: 32]); end
    total++; if (DATA_FROM_L2_VALID !== 1'b0) begin bad++; $display("FAIL refill_valid_low: got %b want 0", DATA_FROM_L2_VALID); end
  endtask

  task automatic test_writeback();
    int e;
    gnt_toggle = 1;
    clear_stats();
    set_line(32'hA000);
    applyStimulus(1'b0, 25'h0, 1'b1, 25'h40, e);
    wait_done(400);
    repeat (5) @(negedge CLK);
    gnt_toggle = 0;
    total++; if (done_cnt != 1) begin bad++; $display("FAIL wb_done_count: got %0d want 1", done_cnt); end
    total++; if (wr_cnt != 32) begin bad++; $display("FAIL wb_beats: got %0d want 32", wr_cnt); end
    for (int k = 0; k < 32; k++) begin
      total++;
      if (wr_addr[k] !== 32'h2000 + 32'(4*k)) begin
        bad++; $display("FAIL wb_addr[%0d]: got %h want %h", k, wr_addr[k], 32'h2000 + 32'(4*k));
      end
      total++;
      if (wr_data[k] !== 32'hA000 + 32'(k)) begin
        bad++; $display("FAIL wb_data[%0d]: got %h want %h", k, wr_data[k], 32'hA000 + 32'(k));
      end
    end
    total++; if (done_cyc != last_wr_cyc + 1) begin bad++; $display("FAIL wb_done_timing: done cycle %0d want %0d", done_cyc, last_wr_cyc + 1); end
    total++; if (rd_cnt != 0 || vld_cnt != 0) begin bad++; $display("FAIL wb_no_reads: reads %0d valids %0d want 0 0", rd_cnt, vld_cnt); end
  endtask

  task automatic test_back_to_back();
    int e;
    gnt_toggle = 0;
    clear_stats();
    set_line(32'hB000);
    applyStimulus(1'b1, 25'h77, 1'b1, 25'h55, e);
    wait_vld(500);
    repeat (5) @(negedge CLK);
    total++; if (wr_cnt != 32) begin bad++; $display("FAIL b2b_writes: got %0d want 32", wr_cnt); end
    total++; if (rd_cnt != 32) begin bad++; $display("FAIL b2b_reads: got %0d want 32", rd_cnt); end
    total++; if (!(last_wr_cyc >= 0 && last_wr_cyc < first_rd_cyc)) begin bad++; $display("FAIL b2b_order: last write %0d first read %0d", last_wr_cyc, first_rd_cyc); end
    total++; if (done_cnt != 1 || vld_cnt != 1) begin bad++; $display("FAIL b2b_pulses: done %0d valid %0d want 1 1", done_cnt, vld_cnt); end
    total++; if (!(done_cyc >= 0 && done_cyc < vld_cyc)) begin bad++; $display("FAIL b2b_done_first: done %0d valid %0d", done_cyc, vld_cyc); end
    total++; if (wr_addr[31] !== 32'h2AFC) begin bad++; $display("FAIL b2b_last_waddr: got %h want 00002afc", wr_addr[31]); end
    total++; if (wr_data[31] !== 32'hB01F) begin bad++; $display("FAIL b2b_last_wdata: got %h want 0000b01f", wr_data[31]); end
    total++; if (rd_addr[0] !== 32'h3B80) begin bad++; $display("FAIL b2b_first_raddr: got %h want 00003b80", rd_addr[0]); end
    total++; if (line_snap[31*32 +: 32] !== 32'h11F) begin bad++; $display("FAIL b2b_slot31: got %h want 0000011f", line_snap[31*32 +: 32]); end
  endtask

  task automatic test_overrun();
    int e;
    clear_stats();
    applyStimulus(1'b1, 25'h10, 1'b0, 25'h0, e);
    repeat (4) @(negedge CLK);
    total++; if (OVERRUN !== 1'b0) begin bad++; $display("FAIL overrun_early: got %b want 0", OVERRUN); end
    applyStimulus(1'b1, 25'h99, 1'b0, 25'h0, e);
    total++; if (OVERRUN !== 1'b1) begin bad++; $display("FAIL overrun_set: got %b want 1", OVERRUN); end
    wait_vld(400);
    repeat (60) @(negedge CLK);
    total++; if (OVERRUN !== 1'b1) begin bad++; $display("FAIL overrun_sticky: got %b want 1", OVERRUN); end
    total++; if (vld_cnt != 1) begin bad++; $display("FAIL overrun_valid_count: got %0d want 1", vld_cnt); end
    total++; if (rd_cnt != 32) begin bad++; $display("FAIL overrun_reads: got %0d want 32", rd_cnt); end
    total++; if (rd_addr[0] !== 32'h800) begin bad++; $display("FAIL overrun_first_addr: got %h want 00000800", rd_addr[0]); end
    total++; if (rd_addr[31] !== 32'h87C) begin bad++; $display("FAIL overrun_last_addr: got %h want 0000087c", rd_addr[31]); end
  endtask

  task automatic test_reset_mid();
    int e;
    clear_stats();
    applyStimulus(1'b1, 25'h200, 1'b0, 25'h0, e);
    for (int i = 0; i < 100 && rd_cnt < 10; i++) @(negedge CLK);
    total++; if (rd_cnt < 10) begin bad++; $display("FAIL midreset_reach_beat10: got %0d want >=10", rd_cnt); end
    total++; if (MEM_ADDR !== 32'h10028) begin bad++; $display("FAIL midreset_beat10_addr: got %h want 00010028", MEM_ADDR); end
    #3 RST_N = 1'b0;
    #1;
    total++; if (MEM_REQ !== 1'b0) begin bad++; $display("FAIL midreset_req: got %b want 0", MEM_REQ); end
    total++; if (MEM_ADDR !== 32'h0) begin bad++; $display("FAIL midreset_addr: got %h want 0", MEM_ADDR); end
    total++; if (OVERRUN !== 1'b0) begin bad++; $display("FAIL midreset_overrun: got %b want 0", OVERRUN); end
    total++; if (DATA_FROM_L2 !== '0) begin bad++; $display("FAIL midreset_line: low word %h want 0", DATA_FROM_L2[31:0]); end
    total++; if (DATA_FROM_L2_VALID !== 1'b0 || WRITE_DONE !== 1'b0) begin bad++; $display("FAIL midreset_pulses: valid %b done %b want 0 0", DATA_FROM_L2_VALID, WRITE_DONE); end
    @(negedge CLK);
    #1 RST_N = 1'b1;
    clear_stats();
    repeat (100) @(negedge CLK);
    total++; if (vld_cnt != 0) begin bad++; $display("FAIL midreset_no_valid: got %0d want 0", vld_cnt); end
    total++; if (rd_cnt != 0 || wr_cnt != 0) begin bad++; $display("FAIL midreset_no_beats: reads %0d writes %0d want 0 0", rd_cnt, wr_cnt); end
  endtask

  task automatic test_wb_forward();
    int e;
    gnt_toggle = 0;
    clear_stats();
    set_line(32'hC000);
    applyStimulus(1'b0, 25'h0, 1'b1, 25'h40, e);
    wait_done(200);
    total++; if (done_cnt != 1) begin bad++; $display("FAIL fwd_wb_done: got %0d want 1", done_cnt); end
    repeat (2) @(negedge CLK);
    clear_stats();
    applyStimulus(1'b1, 25'h40, 1'b0, 25'h0, e);
    wait_vld(200);
    repeat (5) @(negedge CLK);
    total++; if (vld_cnt != 1) begin bad++; $display("FAIL fwd_valid_count: got %0d want 1", vld_cnt); end
`ifdef DCACHE_BRIDGE_WB_FWD_EN
    total++; if (rd_cnt != 0) begin bad++; $display("FAIL fwd_no_reads: got %0d want 0", rd_cnt); end
    total++; if (vld_cyc != e + 2) begin bad++; $display("FAIL fwd_latency: valid cycle %0d want %0d", vld_cyc, e + 2); end
    total++; if (line_snap[7*32 +: 32] !== 32'hC007) begin bad++; $display("FAIL fwd_slot7: got %h want 0000c007", line_snap[7*32 +: 32]); end
    total++; if (line_snap[31*32 +: 32] !== 32'hC01F) begin bad++; $display("FAIL fwd_slot31: got %h want 0000c01f", line_snap[31*32 +: 32]); end
`else
    total++; if (rd_cnt != 32) begin bad++; $display("FAIL nofwd_reads: got %0d want 32", rd_cnt); end
    total++; if (line_snap[7*32 +: 32] !== 32'h107) begin bad++; $display("FAIL nofwd_slot7: got %h want 00000107", line_snap[7*32 +: 32]); end
`endif
  endtask

  initial begin
    clear_stats();
    test_reset();
    test_refill();
    test_writeback();
    test_back_to_back();
    test_overrun();
    test_reset_mid();
    test_wb_forward();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
